dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DWIDTH, default 16, data width of requester and RAM data paths.
REQ-002 Parameter ADDR_WIDTH, default 16, address width of requester and RAM address paths.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester 0 (CPU) / requester 1 (loader) has a command pending.
REQ-006 req0_we / req1_we  input  1  command is a write (1) or read (0).
REQ-007 req0_addr / req1_addr  input  ADDR_WIDTH  command address.
REQ-008 req0_wdata / req1_wdata  input  DWIDTH  write data.
REQ-009 req0_ready / req1_ready  output  1  command accepted this cycle when ANDed with valid.
REQ-010 req0_rvalid / req1_rvalid  output  1  one-cycle pulse, read data valid.
REQ-011 req0_rdata / req1_rdata  output  DWIDTH  read data, held until that requester's next read completes.
REQ-012 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-013 ram_din  output  DWIDTH  RAM write data.
REQ-014 ram_we  output  1  RAM write enable.
REQ-015 ram_dout  input  DWIDTH  RAM read data, registered by RAM, valid the cycle after the address is sampled with ram_we=0.
REQ-016 grant_id  output  1  requester owning the current or last transaction.

Function
REQ-017 FSM states IDLE, ISSUE, DONE; IDLE->ISSUE on any valid; ISSUE->DONE unconditionally; DONE->IDLE unconditionally.
REQ-018 reqN_ready SHALL be high only in IDLE, and only for the granted requester; at most one ready high per cycle.
REQ-019 Arbitration: round-robin; both valid in IDLE -> grant the requester not granted last; one valid -> grant it.
REQ-020 On handshake, we/addr/wdata of the granted requester SHALL be latched; the requester may then change or drop its inputs.
REQ-021 In ISSUE, ram_addr/ram_din SHALL carry the latched values and ram_we SHALL equal the latched we.
REQ-022 ram_we SHALL be 0 in every state other than ISSUE; ram_addr/ram_din hold their last values outside ISSUE.
REQ-023 In DONE, for reads, ram_dout SHALL be captured into the granted requester's rdata; its rvalid pulses high the following cycle (handshake cycle T -> rvalid at T+3).
REQ-024 Writes SHALL produce no rvalid; a write is committed at the ISSUE->DONE edge (T+2).
REQ-025 Maximum acceptance rate: one command per 3 cycles; next ready no earlier than T+3.
REQ-026 Valid deasserted before handshake SHALL be ignored, with no RAM access and no pointer update.
REQ-027 The round-robin pointer SHALL update only on handshake.
REQ-028 A requester holding valid continuously while the other is idle SHALL be granted every 3 cycles.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, ram_we=0, all ready/rvalid=0, ram_addr/ram_din/rdata=0, grant_id=0, pointer such that requester 0 wins the first tie.
REQ-030 Reset asserted in ISSUE SHALL drop ram_we asynchronously; an in-flight read SHALL produce no rvalid after reset release.
REQ-031 The first handshake SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-032 Req0 write addr 0x0010 data 0xA5 at T -> ram_we=1 with ram_addr=0x0010 and ram_din=0x00A5 in cycle T+1 only; no rvalid.
REQ-033 Then req0 read 0x0010 -> req0_rvalid pulse at T+3 with req0_rdata=0x00A5, and req1_rvalid stays 0.
REQ-034 Both valid out of reset -> grant order 0,1,0,1; ready pulses spaced 3 cycles; grant_id follows.
REQ-035 Req1 valid for one cycle while FSM is in ISSUE -> never granted; no RAM access results.
REQ-036 rst_n low during ISSUE of a write -> ram_we drops at once; after release, outputs are at reset values and the first tie grants requester 0.
REQ-037 Req1 read completes with 0x1234, then req1 writes -> req1_rdata holds 0x1234 through the write.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with round-robin grant.
// One command in flight: IDLE accepts, ISSUE drives RAM, DONE returns data.
module dmem_arbiter #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0]     req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DWIDTH-1:0]     req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0]     req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DWIDTH-1:0]     req1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0]     ram_din,
  output logic                  ram_we,
  input  logic [DWIDTH-1:0]     ram_dout,
  output logic                  grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t                state_q;
  logic                  last_q;
  logic                  grant_q;
  logic                  we_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DWIDTH-1:0]     din_q;
  logic [DWIDTH-1:0]     rdata0_q;
  logic [DWIDTH-1:0]     rdata1_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;

  logic                  sel;
  logic                  hs;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0]     sel_din;

  // Pick the winner; a tie goes to whoever was not granted last.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_q;
    end else begin
      sel = req1_valid;
    end
    hs = rst_n && (state_q == IDLE)
      && (req0_valid || req1_valid);
    req0_ready = hs && !sel;
    req1_ready = hs && sel;
    sel_we   = sel ? req1_we    : req0_we;
    sel_addr = sel ? req1_addr  : req0_addr;
    sel_din  = sel ? req1_wdata : req0_wdata;
  end

  // Command FSM with registered RAM and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      we_q      <= 1'b0;
      ram_we_q  <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            state_q  <= ISSUE;
            grant_q  <= sel;
            last_q   <= sel;
            we_q     <= sel_we;
            ram_we_q <= sel_we;
            addr_q   <= sel_addr;
            din_q    <= sel_din;
          end
        end
        ISSUE: begin
          state_q  <= DONE;
          ram_we_q <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
          if (!we_q) begin
            if (grant_q) begin
              rdata1_q  <= ram_dout;
              rvalid1_q <= 1'b1;
            end else begin
              rdata0_q  <= ram_dout;
              rvalid0_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_addr    = addr_q;
  assign ram_din     = din_q;
  assign ram_we      = ram_we_q;
  assign grant_id    = grant_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;

endmodule
